click_token_injector: RTL

Clocked source that injects tokens into the five-stage click pipeline network (IF→ID→EX→MEM→WB). It converts a synchronous valid/ready token stream into the two-phase bundled-data request on the network's IF input. It synchronizes the network's asynchronous IF acknowledge and WB completion request into the clock domain, and tracks the number of tokens in flight. It sits directly upstream of the network: it drives the network's `i_reqL_IF` and consumes its `o_ackL_IF` and `o_reqR_WB`.

---
 rtl/click_token_injector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/click_token_injector.sv
// rtl/click_token_injector.sv - clocked two-phase bundled-data token source for the click pipeline network
// Synchronizes the network IF acknowledge and WB completion, and tracks tokens in flight.
module click_token_injector #(
   parameter int DW           = 32,
   parameter int MAX_INFLIGHT = 5,
   parameter int TIMEOUT      = 255
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_ready,
   output logic          o_reqL_IF,
   output logic [DW-1:0] o_data_IF,
   input  logic          i_ackL_IF,
   input  logic          i_reqR_WB,
   input  logic          i_clr,
   output logic [3:0]    o_inflight,
   output logic          o_done,
   output logic          o_timeout,
   output logic          o_underflow
);

   localparam logic [1:0]  ST_IDLE     = 2'd0;
   localparam logic [1:0]  ST_WAIT_ACK = 2'd1;
   localparam logic [1:0]  ST_ERR      = 2'd2;
   localparam logic [3:0]  MAX_CNT     = 4'(MAX_INFLIGHT);
   localparam logic [15:0] TO_CNT      = 16'(TIMEOUT);

   logic [1:0]    state_q, state_d;
   logic          ack_s1_q, ack_s2_q;
   logic          wb_s1_q, wb_s2_q, wb_s3_q;
   logic          req_q, req_d;
   logic [DW-1:0] data_q, data_d;
   logic [15:0]   timer_q, timer_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          done_q;
   logic          timeout_q, timeout_d;
   logic          uflow_q, uflow_d;
   logic          wb_evt, ack_match, accept, to_hit;

   assign wb_evt    = wb_s2_q ^ wb_s3_q;
   assign ack_match = (ack_s2_q == req_q);
   assign o_ready   = (state_q == ST_IDLE) && (cnt_q < MAX_CNT);
   assign accept    = i_valid && o_ready;
   assign to_hit    = ((timer_q + 16'd1) == TO_CNT);

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      data_d    = data_q;
      timer_d   = timer_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      uflow_d   = uflow_q;

      // Clear is applied first so a same-cycle set event overrides it.
      if (i_clr) begin
         timeout_d = 1'b0;
         uflow_d   = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               req_d   = ~req_q;
               data_d  = i_data;
               timer_d = '0;
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            timer_d = timer_q + 16'd1;
            if (ack_match) begin
               state_d = ST_IDLE;
            end else if (to_hit) begin
               timeout_d = 1'b1;
               state_d   = ST_ERR;
            end
         end
         ST_ERR: begin
            if (i_clr && ack_match) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (wb_evt && (cnt_q == 4'd0)) uflow_d = 1'b1;
      if (accept && !wb_evt) begin
         cnt_d = cnt_q + 4'd1;
      end else if (wb_evt && !accept && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= ST_IDLE;
         ack_s1_q  <= 1'b0;
         ack_s2_q  <= 1'b0;
         wb_s1_q   <= 1'b0;
         wb_s2_q   <= 1'b0;
         wb_s3_q   <= 1'b0;
         req_q     <= 1'b0;
         data_q    <= '0;
         timer_q   <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         uflow_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_s1_q  <= i_ackL_IF;
         ack_s2_q  <= ack_s1_q;
         wb_s1_q   <= i_reqR_WB;
         wb_s2_q   <= wb_s1_q;
         wb_s3_q   <= wb_s2_q;
         req_q     <= req_d;
         data_q    <= data_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         done_q    <= wb_evt;
         timeout_q <= timeout_d;
         uflow_q   <= uflow_d;
      end
   end

   assign o_reqL_IF   = req_q;
   assign o_data_IF   = data_q;
   assign o_inflight  = cnt_q;
   assign o_done      = done_q;
   assign o_timeout   = timeout_q;
   assign o_underflow = uflow_q;

endmodule
